// File: rtl/wt_cache_pkg.sv
// Shared types and constants for the write-through cache fence sequencer.
package wt_cache_pkg;

  localparam int unsigned FENCE_DRAIN_CNT_W = 16;

  typedef enum logic [2:0] {
    FENCE_IDLE    = 3'd0,
    FENCE_WAIT_WB = 3'd1,
    FENCE_DFLUSH  = 3'd2,
    FENCE_IFLUSH  = 3'd3,
    FENCE_DONE    = 3'd4
  } fence_state_e;

  typedef struct packed {
    logic [31:0] cycles;
    logic [15:0] count;
  } fence_perf_t;

endpackage

// File: rtl/wt_fence_timer.sv
// Saturating up-counter with synchronous clear and a count >= threshold compare.
module wt_fence_timer #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear,
  input  logic             enable,
  input  logic [Width-1:0] threshold,
  output logic             hit
);

  logic [Width-1:0] cnt_q;

  // Clear wins over enable; the count sticks at all-ones instead of wrapping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && (cnt_q != '1)) begin
      cnt_q <= cnt_q + Width'(1);
    end
  end

  assign hit = (cnt_q >= threshold);

endmodule

// File: rtl/wt_fence_ctrl.sv
// FENCE / FENCE.I sequencer: drain write buffer, optional D$ flush, I$ flush, ack.
// Define WT_FENCE_PERF_CNT_EN to add the fence_cycles_o / fence_cnt_o counters.
module wt_fence_ctrl
  import wt_cache_pkg::*;
#(
  parameter bit          FlushDcacheOnFenceI = 1'b1,
  parameter int unsigned DrainTimeout        = 1024,
  parameter int unsigned IFlushCycles        = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        fence_req_i,
  input  logic        fence_i_req_i,
  output logic        ack_o,
  output logic        busy_o,
  input  logic        wbuffer_empty_i,
  output logic        dcache_flush_o,
  input  logic        dcache_flush_ack_i,
  output logic        icache_flush_o,
  input  logic        timeout_clr_i,
`ifdef WT_FENCE_PERF_CNT_EN
  output logic [31:0] fence_cycles_o,
  output logic [15:0] fence_cnt_o,
`endif
  output logic        timeout_o
);

  localparam int unsigned IFLUSH_CYCLES = (IFlushCycles < 1) ? 1 : IFlushCycles;
  localparam logic [3:0] IFLUSH_LAST = 4'(IFLUSH_CYCLES - 1);
  // Compare against the pre-increment count so timeout_o rises with the count reaching DrainTimeout.
  localparam logic [FENCE_DRAIN_CNT_W-1:0] DRAIN_LAST = FENCE_DRAIN_CNT_W'(DrainTimeout - 1);

  fence_state_e state_q;
  logic         is_fi_q;
  logic         holdoff_q;
  logic         drain_clr, drain_en, drain_hit;
  logic         iflush_clr, iflush_en, iflush_hit;
  logic         timeout_set;

  assign busy_o      = (state_q != FENCE_IDLE);
  assign drain_clr   = (state_q == FENCE_IDLE);
  assign drain_en    = (state_q == FENCE_WAIT_WB) && !wbuffer_empty_i;
  assign iflush_en   = (state_q == FENCE_IFLUSH);
  assign iflush_clr  = !iflush_en;
  assign timeout_set = (DrainTimeout != 0) && drain_en && drain_hit;

  wt_fence_timer #(
    .Width (FENCE_DRAIN_CNT_W)
  ) u_drain_timer (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear     (drain_clr),
    .enable    (drain_en),
    .threshold (DRAIN_LAST),
    .hit       (drain_hit)
  );

  wt_fence_timer #(
    .Width (4)
  ) u_iflush_timer (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear     (iflush_clr),
    .enable    (iflush_en),
    .threshold (IFLUSH_LAST),
    .hit       (iflush_hit)
  );

  // Flush outputs are set on entry to their state so they line up with it cycle for cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= FENCE_IDLE;
      is_fi_q        <= 1'b0;
      holdoff_q      <= 1'b0;
      ack_o          <= 1'b0;
      dcache_flush_o <= 1'b0;
      icache_flush_o <= 1'b0;
      timeout_o      <= 1'b0;
    end else begin
      ack_o     <= 1'b0;
      holdoff_q <= 1'b0;
      case (state_q)
        FENCE_IDLE: begin
          if ((fence_req_i || fence_i_req_i) && !holdoff_q) begin
            is_fi_q <= fence_i_req_i;
            state_q <= FENCE_WAIT_WB;
          end
        end
        FENCE_WAIT_WB: begin
          if (wbuffer_empty_i) begin
            if (is_fi_q && FlushDcacheOnFenceI) begin
              state_q        <= FENCE_DFLUSH;
              dcache_flush_o <= 1'b1;
            end else if (is_fi_q) begin
              state_q        <= FENCE_IFLUSH;
              icache_flush_o <= 1'b1;
            end else begin
              state_q <= FENCE_DONE;
              ack_o   <= 1'b1;
            end
          end
        end
        FENCE_DFLUSH: begin
          if (dcache_flush_ack_i) begin
            dcache_flush_o <= 1'b0;
            icache_flush_o <= 1'b1;
            state_q        <= FENCE_IFLUSH;
          end
        end
        FENCE_IFLUSH: begin
          if (iflush_hit) begin
            icache_flush_o <= 1'b0;
            ack_o          <= 1'b1;
            state_q        <= FENCE_DONE;
          end
        end
        FENCE_DONE: begin
          holdoff_q <= 1'b1;
          state_q   <= FENCE_IDLE;
        end
        default: state_q <= FENCE_IDLE;
      endcase

      if (timeout_set) begin
        timeout_o <= 1'b1;
      end else if (timeout_clr_i) begin
        timeout_o <= 1'b0;
      end
    end
  end

`ifdef WT_FENCE_PERF_CNT_EN
  fence_perf_t perf_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_q <= '0;
    end else begin
      if (busy_o) perf_q.cycles <= perf_q.cycles + 32'd1;
      if (ack_o)  perf_q.count  <= perf_q.count + 16'd1;
    end
  end

  assign fence_cycles_o = perf_q.cycles;
  assign fence_cnt_o    = perf_q.count;
`endif

endmodule

// File: tb/tb_wt_fence_ctrl.sv
// Randomized and directed bench for wt_fence_ctrl against a timeline model.
// Perf counter checks compile in only when WT_FENCE_PERF_CNT_EN is defined.
module tb_wt_fence_ctrl;

  localparam bit FLUSH_D  = 1'b1;
  localparam int DRAIN_TO = 8;
  localparam int IC       = 2;

  logic clk_i = 1'b0;
  logic rst_ni, fence_req_i, fence_i_req_i, wbuffer_empty_i, dcache_flush_ack_i, timeout_clr_i;
  logic ack_o, busy_o, dcache_flush_o, icache_flush_o, timeout_o;
`ifdef WT_FENCE_PERF_CNT_EN
  logic [31:0] fence_cycles_o;
  logic [15:0] fence_cnt_o;
`endif

  int   checks = 0;
  int   errors = 0;
  logic tmo_model = 1'b0;

  always #5 clk_i = ~clk_i;

  wt_fence_ctrl #(
    .FlushDcacheOnFenceI (FLUSH_D),
    .DrainTimeout        (DRAIN_TO),
    .IFlushCycles        (IC)
  ) dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .fence_req_i        (fence_req_i),
    .fence_i_req_i      (fence_i_req_i),
    .ack_o              (ack_o),
    .busy_o             (busy_o),
    .wbuffer_empty_i    (wbuffer_empty_i),
    .dcache_flush_o     (dcache_flush_o),
    .dcache_flush_ack_i (dcache_flush_ack_i),
    .icache_flush_o     (icache_flush_o),
    .timeout_clr_i      (timeout_clr_i),
`ifdef WT_FENCE_PERF_CNT_EN
    .fence_cycles_o     (fence_cycles_o),
    .fence_cnt_o        (fence_cnt_o),
`endif
    .timeout_o          (timeout_o)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic fr, input logic fir, input logic emp,
                               input logic dack, input logic clr);
    fence_req_i        = fr;
    fence_i_req_i      = fir;
    wbuffer_empty_i    = emp;
    dcache_flush_ack_i = dack;
    timeout_clr_i      = clr;
  endtask

  task automatic stepCycle();
    @(posedge clk_i);
    #1;
  endtask

  // Idle cycles with requests low; spurious D$ acks must be ignored.
  task automatic idleCycles(input int n, input int clr_at);
    for (int c = 0; c < n; c++) begin
      checkOutput($sformatf("idle busy c%0d", c), busy_o, 1'b0);
      checkOutput($sformatf("idle ack c%0d", c), ack_o, 1'b0);
      checkOutput($sformatf("idle dflush c%0d", c), dcache_flush_o, 1'b0);
      checkOutput($sformatf("idle iflush c%0d", c), icache_flush_o, 1'b0);
      checkOutput($sformatf("idle timeout c%0d", c), timeout_o, tmo_model);
      applyStimulus(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), c == clr_at);
      if (c == clr_at) tmo_model = 1'b0;
      stepCycle();
    end
  endtask

  // kind: 0=FENCE, 1=FENCE.I, 2=both. w = stall cycles in drain, d = D$ ack delay.
  // Request raised at relative cycle 0 and held through the holdoff cycle a+1.
  task automatic runFence(input int kind, input int w, input int d, input int clr_at, input bit noise);
    bit fi;
    int a, ifs, dfs, dfe;
    logic emp, dack, fir;
    fi  = (kind != 0);
    dfs = 2 + w;
    dfe = 2 + w + d;
    ifs = (fi && FLUSH_D) ? 3 + w + d : 2 + w;
    a   = fi ? ifs + IC : 2 + w;
    for (int c = 0; c <= a + 1; c++) begin
      checkOutput($sformatf("busy k%0d c%0d", kind, c), busy_o, (c >= 1) && (c <= a));
      checkOutput($sformatf("ack k%0d c%0d", kind, c), ack_o, c == a);
      checkOutput($sformatf("dflush k%0d c%0d", kind, c), dcache_flush_o,
                  fi && FLUSH_D && (c >= dfs) && (c <= dfe));
      checkOutput($sformatf("iflush k%0d c%0d", kind, c), icache_flush_o,
                  fi && (c >= ifs) && (c < ifs + IC));
      checkOutput($sformatf("timeout k%0d c%0d", kind, c), timeout_o, tmo_model);
      emp = (c > w);
      if (fi && FLUSH_D && (c >= dfs) && (c <= dfe)) dack = (c == dfe);
      else dack = 1'($urandom_range(0, 3) == 0);
      fir = (kind != 0) || (noise && (c >= 1) && (c <= a) && ($urandom_range(0, 1) != 0));
      applyStimulus(kind != 1, fir, emp, dack, c == clr_at);
      if ((c >= DRAIN_TO) && (c <= w)) tmo_model = 1'b1;
      else if (c == clr_at) tmo_model = 1'b0;
      stepCycle();
    end
  endtask

  initial begin
    int kind, w, d, clr_at, gap;
    bit noise;
    rst_ni = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("rst ack", ack_o, 1'b0);
    checkOutput("rst busy", busy_o, 1'b0);
    checkOutput("rst dflush", dcache_flush_o, 1'b0);
    checkOutput("rst iflush", icache_flush_o, 1'b0);
    checkOutput("rst timeout", timeout_o, 1'b0);
`ifdef WT_FENCE_PERF_CNT_EN
    checkOutput("rst perf cycles", fence_cycles_o, 32'd0);
    checkOutput("rst perf cnt", fence_cnt_o, 32'd0);
`endif
    @(negedge clk_i);
    rst_ni = 1'b1;
    stepCycle();
    idleCycles(3, -1);

    $display("[TB] directed: FENCE, FENCE.I, both, drain timeout");
    runFence(0, 0, 0, -1, 1'b0);
    runFence(1, 3, 3, -1, 1'b0);
    runFence(2, 0, 0, -1, 1'b0);
    idleCycles(2, -1);
    runFence(0, 20, 0, -1, 1'b0);
    idleCycles(3, 1);

    $display("[TB] directed: reset during D$ flush");
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    stepCycle();
    checkOutput("rstmid wait busy", busy_o, 1'b1);
    stepCycle();
    checkOutput("rstmid dflush before", dcache_flush_o, 1'b1);
    #2;
    rst_ni = 1'b0;
    #1;
    checkOutput("rstmid dflush async", dcache_flush_o, 1'b0);
    checkOutput("rstmid busy async", busy_o, 1'b0);
    checkOutput("rstmid iflush async", icache_flush_o, 1'b0);
    checkOutput("rstmid ack async", ack_o, 1'b0);
    tmo_model = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    stepCycle();

    $display("[TB] directed: back-to-back FENCEs after reset");
    runFence(0, 0, 0, -1, 1'b0);
    runFence(0, 0, 0, -1, 1'b0);
    runFence(0, 0, 0, -1, 1'b0);
`ifdef WT_FENCE_PERF_CNT_EN
    checkOutput("perf cnt", fence_cnt_o, 32'd3);
    checkOutput("perf cycles", fence_cycles_o, 32'd6);
`endif
    idleCycles(1, -1);

    $display("[TB] random sequences");
    for (int t = 0; t < 25; t++) begin
      kind   = $urandom_range(0, 2);
      w      = $urandom_range(0, 11);
      d      = $urandom_range(0, 3);
      clr_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 14)) : -1;
      noise  = 1'($urandom_range(0, 1));
      runFence(kind, w, d, clr_at, noise);
      gap = $urandom_range(0, 2);
      idleCycles(gap, ($urandom_range(0, 1) != 0) ? 0 : -1);
    end
    idleCycles(2, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wt_fence_ctrl.md
Name: wt_fence_ctrl

Overview:
Sequences FENCE and FENCE.I maintenance operations across the write-through cache subsystem: drains the D$ write buffer, optionally flushes the D$, then flushes the I$, and acknowledges the commit stage. Sits between the controller/commit logic and the wt_cache_subsystem flush and status ports. Provides a single serialized owner of the flush resources, so neither cache sees overlapping flush requests.

Parameters:
FlushDcacheOnFenceI, 1'b1, FENCE.I also runs a D$ flush handshake before the I$ flush.
DrainTimeout, 1024, maximum cycles in WAIT_WB before timeout_o is raised; 0 disables the timeout.
IFlushCycles, 1, cycles icache_flush_o is held high (range 1..15).

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
fence_req_i  in  1  FENCE request; level, held until ack_o
fence_i_req_i  in  1  FENCE.I request; level, held until ack_o
ack_o  out  1  single-cycle completion pulse
busy_o  out  1  sequence in progress (state != IDLE)
wbuffer_empty_i  in  1  D$ write buffer empty
dcache_flush_o  out  1  D$ flush request, held until acknowledged
dcache_flush_ack_i  in  1  single-cycle D$ flush acknowledge
icache_flush_o  out  1  I$ flush (flush and kill)
timeout_o  out  1  sticky drain-timeout flag
timeout_clr_i  in  1  clears timeout_o

Behaviour:
- Clock and reset: one clock, clk_i. rst_ni is asynchronous and active-low. At reset all outputs are 0, state is IDLE, all counters are 0, and the holdoff flag is 0.
- FSM states: IDLE, WAIT_WB, DFLUSH, IFLUSH, DONE.
- IDLE: if (fence_req_i | fence_i_req_i) and holdoff is clear:
  - latch is_fi = fence_i_req_i; if both requests are high, the sequence is treated as FENCE.I.
  - go to WAIT_WB; clear the drain counter.
- WAIT_WB:
  - wbuffer_empty_i=1: go to DFLUSH if is_fi & FlushDcacheOnFenceI; else go to IFLUSH if is_fi; else go to DONE.
  - Each cycle empty=0, the 16-bit saturating drain counter increments.
  - When the counter reaches DrainTimeout (nonzero), set timeout_o. The FSM keeps waiting; there is no abort.
- DFLUSH:
  - dcache_flush_o=1 from the first DFLUSH cycle.
  - On dcache_flush_ack_i, dcache_flush_o drops in the next cycle and the FSM goes to IFLUSH.
  - An ack arriving outside DFLUSH is ignored.
- IFLUSH:
  - icache_flush_o=1 for exactly IFLUSH_CYCLES consecutive cycles, where IFLUSH_CYCLES = max(IFlushCycles,1); a 4-bit counter tracks this.
  - Then go to DONE.
- DONE: ack_o=1 for one cycle; go to IDLE; set holdoff for one cycle. The requester drops its request in the cycle after ack, and holdoff prevents that stale request from restarting a sequence.
- Latencies:
  - FENCE with the buffer already empty: request cycle N, ack_o at N+2.
  - FENCE.I with the buffer empty, immediate D$ ack, and IFlushCycles=1: ack_o at N+4.
- Requests while busy do not change is_fi.
- Dropping a request mid-sequence is illegal; the sequence still completes and ack_o still pulses.
- timeout_o is cleared by timeout_clr_i. If clear and set occur in the same cycle, set wins.
- All outputs are registered except busy_o, which is decoded from the state register.
- A reset mid-sequence returns to IDLE immediately and deasserts all flush outputs asynchronously.

Optional Feature:
- Macro: WT_FENCE_PERF_CNT_EN.
- Defined:
  - adds output fence_cycles_o [31:0], which counts every cycle with busy_o=1 (wrapping);
  - adds output fence_cnt_o [15:0], which increments on each ack_o (wrapping);
  - both reset to 0.
- Undefined: the ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- wt_cache_pkg gets:
  - the fence_state_e enum (5 states, 3-bit encoding);
  - the constant FENCE_DRAIN_CNT_W = 16;
  - the struct fence_perf_t {cycles[31:0], count[15:0]}.
- One sub-module, wt_fence_timer: a generic saturating up-counter with clear, enable and a threshold-compare output. It is used for both the drain timeout and the IFLUSH hold counter.

Test Plan:
- FENCE with wbuffer_empty_i=1, request at cycle 10 → ack_o at cycle 12 only; dcache_flush_o and icache_flush_o stay 0.
- FENCE.I, wbuffer empty goes to 1 at cycle 20, D$ ack 3 cycles after dcache_flush_o rises, IFlushCycles=2 → icache_flush_o high for exactly 2 cycles, ack_o one cycle later, busy_o low the cycle after that.
- fence_req_i and fence_i_req_i raised together → full FENCE.I sequence; a single ack_o; no second sequence while the requester still holds its request during the holdoff cycle.
- DrainTimeout=8, wbuffer_empty_i held 0 for 20 cycles → timeout_o rises after 8 waiting cycles and stays set. Then empty=1 → sequence completes. timeout_clr_i pulse → timeout_o=0.
- rst_ni asserted while in DFLUSH → dcache_flush_o=0 immediately; after release, state is IDLE and a new FENCE completes normally.
- With WT_FENCE_PERF_CNT_EN: three back-to-back FENCEs with the buffer empty → fence_cnt_o=3 and fence_cycles_o=6.
